// File: rtl/si534x_cfg_seq.sv
// Si534x register-load sequencer: walks a {page, reg, data...} ROM and streams
// I2C write transactions to a byte-level master, skipping redundant page writes.
module si534x_cfg_seq #(
  parameter int unsigned           MEM_DEPTH    = 326,
  parameter int unsigned           MEM_WIDTH    = 24,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter logic [6:0]            SLAVE_ADDR   = 7'h74,
  parameter logic [DATA_WIDTH-1:0] PAGE_REG     = 8'h01,
  parameter int unsigned           PAUSE_IDX    = 2,
  parameter int unsigned           PAUSE_CYCLES = 37_500_000,
  parameter int unsigned           ADDR_W       = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  start_i,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [MEM_WIDTH-1:0]  rom_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_first_o,
  output logic                  m_last_o,
  input  logic                  xfer_done_i,
  input  logic                  nack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     entry_idx_o
);

  localparam int unsigned NB   = MEM_WIDTH / DATA_WIDTH;
  localparam int unsigned BC_W = $clog2(NB);
  localparam int unsigned PC_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [DATA_WIDTH-1:0] ADDR_BYTE = DATA_WIDTH'({SLAVE_ADDR, 1'b0});

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_PG_TX, S_PG_WAIT,
    S_WR_TX, S_WR_WAIT, S_PAUSE, S_DONE, S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [MEM_WIDTH-1:0]  entry_q, entry_d;
  logic [DATA_WIDTH-1:0] cache_q, cache_d;
  logic                  cache_vld_q, cache_vld_d;
  logic [BC_W-1:0]       bcnt_q, bcnt_d;
  logic [PC_W-1:0]       pcnt_q, pcnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Byte i of the current transaction; index 0 is always the address byte.
  function automatic logic [DATA_WIDTH-1:0] tx_byte(input logic pg,
                                                    input logic [MEM_WIDTH-1:0] entry,
                                                    input logic [BC_W-1:0] i);
    logic [DATA_WIDTH-1:0] b;
    logic [MEM_WIDTH-1:0]  sh;
    sh = entry >> (DATA_WIDTH * (NB - 1 - 32'(i)));
    if (i == '0)    b = ADDR_BYTE;
    else if (!pg)   b = sh[DATA_WIDTH-1:0];
    else if (i == BC_W'(1)) b = PAGE_REG;
    else            b = entry[MEM_WIDTH-1 -: DATA_WIDTH];
    return b;
  endfunction

  always_comb begin
    logic [BC_W-1:0] nxt;
    logic            is_pg;
    state_d     = state_q;
    idx_d       = idx_q;
    entry_d     = entry_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    bcnt_d      = bcnt_q;
    pcnt_d      = pcnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    first_d     = first_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    nxt         = bcnt_q + BC_W'(1);
    is_pg       = (state_q == S_PG_TX);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_FETCH;
          idx_d       = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cache_vld_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        entry_d = rom_data_i;
        bcnt_d  = '0;
        valid_d = 1'b1;
        data_d  = ADDR_BYTE;
        first_d = 1'b1;
        last_d  = 1'b0;
        if (!cache_vld_q || (cache_q != rom_data_i[MEM_WIDTH-1 -: DATA_WIDTH]))
          state_d = S_PG_TX;
        else
          state_d = S_WR_TX;
      end
      S_PG_TX, S_WR_TX: begin
        if (valid_q && m_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = is_pg ? S_PG_WAIT : S_WR_WAIT;
          end else begin
            bcnt_d  = nxt;
            data_d  = tx_byte(is_pg, entry_q, nxt);
            first_d = 1'b0;
            last_d  = is_pg ? (nxt == BC_W'(2)) : (nxt == BC_W'(NB - 1));
          end
        end
      end
      S_PG_WAIT: begin
        if (xfer_done_i) begin
          if (nack_i) begin
            state_d = S_ERR;
          end else begin
            cache_d     = entry_q[MEM_WIDTH-1 -: DATA_WIDTH];
            cache_vld_d = 1'b1;
            bcnt_d      = '0;
            valid_d     = 1'b1;
            data_d      = ADDR_BYTE;
            first_d     = 1'b1;
            state_d     = S_WR_TX;
          end
        end
      end
      S_WR_WAIT: begin
        if (xfer_done_i) begin
          if (nack_i) begin
            state_d = S_ERR;
          end else if (idx_q == ADDR_W'(MEM_DEPTH - 1)) begin
            state_d = S_DONE;
          end else if (32'(idx_q) == PAUSE_IDX) begin
            pcnt_d  = PC_W'(PAUSE_CYCLES - 1);
            state_d = S_PAUSE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_PAUSE: begin
        if (pcnt_q == '0) begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          pcnt_d = pcnt_q - PC_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      entry_q     <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      bcnt_q      <= '0;
      pcnt_q      <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      entry_q     <= entry_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
      bcnt_q      <= bcnt_d;
      pcnt_q      <= pcnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      first_q     <= first_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rom_addr_o  = idx_q;
  assign entry_idx_o = idx_q;
  assign m_data_o    = data_q;
  assign m_valid_o   = valid_q;
  assign m_first_o   = first_q;
  assign m_last_o    = last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_si534x_cfg_seq.sv
// Directed bench for si534x_cfg_seq: a 24-bit/4-entry instance with a pause after
// entry 0, and a 32-bit/2-entry instance, driven by a small byte-master model.
module tb_si534x_cfg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arstn, start_a, start_b;
  logic [1:0] ready, xdone, nackv;
  logic [1:0] mv, mf, ml;
  logic [1:0][7:0] md;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [1:0] rom_addr_a, idx_a;
  logic [0:0] rom_addr_b, idx_b;
  logic [23:0] rom_data_a;
  logic [31:0] rom_data_b;

  si534x_cfg_seq #(.MEM_DEPTH(4), .MEM_WIDTH(24), .DATA_WIDTH(8), .SLAVE_ADDR(7'h74),
                   .PAGE_REG(8'h01), .PAUSE_IDX(0), .PAUSE_CYCLES(10)) u_a (
    .clk_i(clk), .arstn_i(arstn), .start_i(start_a),
    .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
    .m_data_o(md[0]), .m_valid_o(mv[0]), .m_ready_i(ready[0]),
    .m_first_o(mf[0]), .m_last_o(ml[0]),
    .xfer_done_i(xdone[0]), .nack_i(nackv[0]),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .entry_idx_o(idx_a));

  si534x_cfg_seq #(.MEM_DEPTH(2), .MEM_WIDTH(32), .DATA_WIDTH(8), .SLAVE_ADDR(7'h74),
                   .PAGE_REG(8'h01), .PAUSE_IDX(7), .PAUSE_CYCLES(1)) u_b (
    .clk_i(clk), .arstn_i(arstn), .start_i(start_b),
    .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
    .m_data_o(md[1]), .m_valid_o(mv[1]), .m_ready_i(ready[1]),
    .m_first_o(mf[1]), .m_last_o(ml[1]),
    .xfer_done_i(xdone[1]), .nack_i(nackv[1]),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .entry_idx_o(idx_b));

  // Synchronous ROMs: data follows the address by one clock.
  always @(posedge clk) begin
    case (rom_addr_a)
      2'd0: rom_data_a <= 24'h010B68;
      2'd1: rom_data_a <= 24'h010C01;
      2'd2: rom_data_a <= 24'h021AFF;
      default: rom_data_a <= 24'h021B00;
    endcase
    rom_data_b <= (rom_addr_b == 1'b0) ? 32'h0510AA55 : 32'h05111234;
  end

  // Byte master model: optional stall per byte, STOP done three clocks after last byte.
  int stall_len = 0, nack_txn = -1;
  int txn_cnt = 0, viol = 0, both = 0, cyc = 0, xd_cyc = 0, gap = 0;
  int scnt [2], dtmr [2];
  logic [9:0] held [2];
  logic [1:0] prev_addr_a = '0;
  logic [10:0] got [$];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      xdone[k] = 1'b0;
      nackv[k] = 1'b0;
      if (!arstn) begin
        ready[k] = 1'b0; scnt[k] = 0; dtmr[k] = 0;
        continue;
      end
      if (dtmr[k] > 0) begin
        dtmr[k]--;
        if (dtmr[k] == 0) begin
          xdone[k] = 1'b1;
          nackv[k] = (txn_cnt == nack_txn);
          txn_cnt++;
          if (k == 0) xd_cyc = cyc;
        end
      end
      if (mv[k]) begin
        if (mf[k] && ml[k]) both++;
        if (scnt[k] > 0 && {mf[k], ml[k], md[k]} !== held[k]) viol++;
        held[k] = {mf[k], ml[k], md[k]};
        if (scnt[k] < stall_len) begin
          ready[k] = 1'b0; scnt[k]++;
        end else begin
          ready[k] = 1'b1; scnt[k] = 0;
          got.push_back({k[0], mf[k], ml[k], md[k]});
          if (ml[k]) dtmr[k] = 3;
        end
      end else begin
        if (scnt[k] > 0) viol++;
        ready[k] = 1'b0; scnt[k] = 0;
      end
    end
    if (rom_addr_a != prev_addr_a && rom_addr_a == 2'd1) gap = cyc - xd_cyc;
    prev_addr_a = rom_addr_a;
  end

  int n_cmp = 0, n_fail = 0;
  logic [7:0] exp_bytes [$];
  int exp_lens [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag, input int base, input bit inst, input int ntx);
    int k = 0, total = 0;
    for (int t = 0; t < ntx; t++) total += exp_lens[t];
    chk({tag, "_count"}, 64'(got.size() - base), 64'(total));
    for (int t = 0; t < ntx; t++)
      for (int p = 0; p < exp_lens[t]; p++) begin
        chk($sformatf("%s_byte%0d", tag, k),
            (base + k < got.size()) ? 64'(got[base + k]) : 64'h7FF,
            64'({inst, p == 0, p == exp_lens[t] - 1, exp_bytes[k]}));
        k++;
      end
  endtask

  task automatic wait_end(input bit inst, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (inst ? (!busy_b && (done_b || err_b)) : (!busy_a && (done_a || err_a))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_exp_a();
    exp_bytes = '{8'hE8, 8'h01, 8'h01, 8'hE8, 8'h0B, 8'h68, 8'hE8, 8'h0C, 8'h01,
                  8'hE8, 8'h01, 8'h02, 8'hE8, 8'h1A, 8'hFF, 8'hE8, 8'h1B, 8'h00};
    exp_lens  = '{3, 3, 3, 3, 3, 3};
  endtask

  initial begin
    bit ok;
    int base;
    arstn = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a", 64'({busy_a, done_a, err_a, mv[0], mf[0], ml[0], md[0], idx_a, rom_addr_a}), 64'd0);
    chk("rst_b", 64'({busy_b, done_b, err_b, mv[1], mf[1], ml[1], md[1], idx_b, rom_addr_b}), 64'd0);
    arstn = 1'b1;
    repeat (2) @(negedge clk);

    // Run 1: always ready, ACK, with a second start while busy.
    set_exp_a();
    base = got.size();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk("r1_busy", 64'(busy_a), 64'd1);
    repeat (4) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_end(1'b0, 3000, ok);
    chk("r1_end", 64'(ok), 64'd1);
    chk_stream("r1", base, 1'b0, 6);
    chk("r1_flags", 64'({busy_a, done_a, err_a, idx_a}), 64'({1'b0, 1'b1, 1'b0, 2'd3}));
    // xfer_done sampled one edge after xd_cyc; 10 pause clocks, then seen at next negedge.
    chk("r1_pause_gap", 64'(gap), 64'd11);

    // Run 2: five-clock stall on every byte.
    stall_len = 5;
    base = got.size();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk("r2_done_clr", 64'({busy_a, done_a}), 64'({1'b1, 1'b0}));
    wait_end(1'b0, 5000, ok);
    chk("r2_end", 64'(ok), 64'd1);
    chk_stream("r2", base, 1'b0, 6);
    chk("r2_done", 64'(done_a), 64'd1);
    stall_len = 0;

    // Run 3: NACK on the page write of entry 2 (fourth transaction).
    nack_txn = txn_cnt + 3;
    base = got.size();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_end(1'b0, 3000, ok);
    chk("r3_end", 64'(ok), 64'd1);
    chk_stream("r3", base, 1'b0, 4);
    chk("r3_flags", 64'({busy_a, done_a, err_a, idx_a}), 64'({1'b0, 1'b0, 1'b1, 2'd2}));
    nack_txn = -1;

    // Run 4: reset mid-stream, then a clean restart.
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 20 && !mv[0]; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    #2 arstn = 1'b0;
    #1 chk("r4_async_rst", 64'({busy_a, done_a, err_a, mv[0], mf[0], ml[0], md[0], idx_a, rom_addr_a}), 64'd0);
    @(negedge clk); @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    base = got.size();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_end(1'b0, 3000, ok);
    chk("r4_end", 64'(ok), 64'd1);
    chk_stream("r4", base, 1'b0, 6);
    chk("r4_done", 64'({done_a, err_a}), 64'({1'b1, 1'b0}));

    // Run 5: 32-bit entries with two data bytes; latency from start.
    exp_bytes = '{8'hE8, 8'h01, 8'h05, 8'hE8, 8'h10, 8'hAA, 8'h55, 8'hE8, 8'h11, 8'h12, 8'h34};
    exp_lens  = '{3, 4, 4};
    base = got.size();
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    chk("r5_clk1", 64'({busy_b, mv[1], rom_addr_b}), 64'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    chk("r5_clk2_valid", 64'(mv[1]), 64'd0);
    @(negedge clk);
    chk("r5_clk3_first", 64'({mv[1], mf[1], ml[1], md[1]}), 64'({1'b1, 1'b1, 1'b0, 8'hE8}));
    wait_end(1'b1, 3000, ok);
    chk("r5_end", 64'(ok), 64'd1);
    chk_stream("r5", base, 1'b1, 3);
    chk("r5_flags", 64'({busy_b, done_b, err_b, idx_b}), 64'({1'b0, 1'b1, 1'b0, 1'b1}));

    chk("stall_stability", 64'(viol), 64'd0);
    chk("first_last_excl", 64'(both), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/si534x_cfg_seq.md
# si534x_cfg_seq

Parametrised register-load sequencer for Si534x-family clock generators. Walks a configuration ROM of `{page, register, data…}` entries and emits I2C write transactions as a byte stream to the I2C master. It inserts a page-select write only when the page changes, and holds a programmable settle pause after a chosen entry. It sits between the configuration ROM and the byte-level I2C master, under control of the board bring-up logic.

## Interface
- `MEM_DEPTH`, 326, number of ROM entries.
- `MEM_WIDTH`, 24, entry width; a multiple of `DATA_WIDTH` and at least `3*DATA_WIDTH`.
- `DATA_WIDTH`, 8, byte width on the stream.
- `SLAVE_ADDR`, 7'h74, 7-bit device address.
- `PAGE_REG`, 8'h01, register address of the page-select register.
- `PAUSE_IDX`, 2, entry index after which the pause is inserted; a value ≥ `MEM_DEPTH` disables the pause.
- `PAUSE_CYCLES`, 37_500_000, pause length in clocks (300 ms at 125 MHz); must be ≥ 1.
- `ADDR_W`, `$clog2(MEM_DEPTH)`, ROM address width.

Ports:
- `clk_i`  in  1  system clock.
- `arstn_i`  in  1  asynchronous active-low reset.
- `start_i`  in  1  one-cycle start pulse; ignored while `busy_o`=1.
- `rom_addr_o`  out  `ADDR_W`  ROM read address.
- `rom_data_i`  in  `MEM_WIDTH`  ROM data; valid one clock after `rom_addr_o` changes.
- `m_data_o`  out  `DATA_WIDTH`  stream byte.
- `m_valid_o`  out  1  byte valid.
- `m_ready_i`  in  1  master accepts byte.
- `m_first_o`  out  1  byte is the address byte; the master issues START before it.
- `m_last_o`  out  1  final byte of the transaction; the master issues STOP after it.
- `xfer_done_i`  in  1  pulse: the master finished STOP for the current transaction.
- `nack_i`  in  1  sampled with `xfer_done_i`; 1 means NACK was seen.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  sticky: all entries written.
- `err_o`  out  1  sticky: aborted on NACK.
- `entry_idx_o`  out  `ADDR_W`  index of the entry being processed.

## Operation
- Entry layout: page = `[MEM_WIDTH-1 -: DATA_WIDTH]`. The next byte down is the register address. The remaining `MEM_WIDTH/DATA_WIDTH-2` bytes are data, sent MSB-first.
- Address byte is `{SLAVE_ADDR, 1'b0}` (write).
- State machine:
  - IDLE
    - `start_i` → FETCH.
    - Clear `done_o`, `err_o`, `entry_idx_o`.
    - Invalidate the page cache.
    - Set `busy_o`.
  - FETCH: drive `rom_addr_o`=`entry_idx_o`; one clock → LATCH.
  - LATCH
    - Register `rom_data_i`.
    - If the cache is invalid or the cached page ≠ the entry page → PG_TX.
    - Otherwise → WR_TX.
  - PG_TX
    - Stream 3 bytes: address, `PAGE_REG`, page.
    - After the last byte is accepted → PG_WAIT.
  - PG_WAIT
    - On `xfer_done_i`: if `nack_i` → ERR.
    - Otherwise load the page cache, mark it valid → WR_TX.
  - WR_TX
    - Stream the address byte, then the register byte, then the data bytes.
    - After the last byte is accepted → WR_WAIT.
  - WR_WAIT
    - On `xfer_done_i`: if `nack_i` → ERR.
    - Else if idx = `MEM_DEPTH-1` → DONE.
    - Else if idx = `PAUSE_IDX` → PAUSE.
    - Else idx+1 → FETCH.
  - PAUSE: count `PAUSE_CYCLES` clocks, then idx+1 → FETCH.
  - DONE: `done_o`=1, `busy_o`=0 → IDLE.
  - ERR
    - `err_o`=1, `busy_o`=0 → IDLE.
    - `entry_idx_o` holds the failing index.
- A NACK on a page write aborts before the register write.
- `xfer_done_i` outside PG_WAIT/WR_WAIT is ignored.

## Timing
- Reset: all outputs 0; state IDLE; page cache invalid; pause counter 0. Asynchronous assertion, synchronous deassertion handled by the system reset bridge.
- Reset mid-transaction: `m_valid_o` drops immediately. The master must discard the partial transaction.
- `start_i` to the first `rom_addr_o`: 1 clock. To the first `m_valid_o`: 3 clocks.
- Handshake:
  - A byte transfers on `m_valid_o && m_ready_i`.
  - `m_data_o`, `m_first_o` and `m_last_o` stay stable while `m_valid_o && !m_ready_i`.
  - The next byte is valid on the clock after acceptance, with no bubble within a transaction.
  - `m_valid_o`=0 in the WAIT states.
- `m_first_o` and `m_last_o` are never both 1.
- After `xfer_done_i`, the next FETCH starts on the following clock.
- Pause: exactly `PAUSE_CYCLES` clocks from leaving WR_WAIT to entering FETCH.
- `done_o` and `err_o` stay asserted until the next accepted `start_i`.

## Test plan
- Run with `MEM_DEPTH`=4 and ROM {01_0B_68, 01_0C_01, 02_1A_FF, 02_1B_00}, master always ready, ACK.
  - Streams: [E8,01,01][E8,0B,68][E8,0C,01][E8,01,02][E8,1A,FF][E8,1B,00].
  - Then `done_o`=1 and `busy_o`=0.
- Run with `PAUSE_IDX`=0 and `PAUSE_CYCLES`=10 → exactly 10 idle clocks between `xfer_done_i` of entry 0 and the next `rom_addr_o`=1.
- Hold `m_ready_i` low for 5 clocks on each byte → data and flags stay stable; byte order is unchanged.
- Return `nack_i`=1 on the page write of entry 2 → `err_o`=1, `entry_idx_o`=2, and no register write for entry 2.
- Pulse `start_i` while busy → ignored. Pulse `arstn_i` low mid-stream → all outputs 0. A new start then re-emits the page write for entry 0.
- Run with `MEM_WIDTH`=32 and entry 05_10_AA_55 → streams [E8,01,05][E8,10,AA,55].
